// File: rtl/mat_load_ctrl.sv
// Matrix register load sequencer: turns a load command plus a vector stream
// into registered row/column/diagonal writes, with an optional transpose tail.

package mat_load_pkg;

    typedef enum logic [2:0] {
        MAT_DATA_WRITE_DISABLE   = 3'd0,
        MAT_DATA_WRITE_ROW       = 3'd1,
        MAT_DATA_WRITE_COL       = 3'd2,
        MAT_DATA_WRITE_DIAG      = 3'd3,
        MAT_DATA_WRITE_TRANSPOSE = 3'd4
    } MatDataWriteOp_t;

    // One lane is the IEEE-754 single-precision bit pattern of a shortreal.
    typedef logic [31:0] lane_t;

endpackage

module mat_load_ctrl
    import mat_load_pkg::*;
#(
    parameter int WIDTH           = 128,
    parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH)
) (
    input  logic                       clock,
    input  logic                       reset,

    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_mode,
    input  logic [WIDTH_ADDR_SIZE-1:0] cmd_start,
    input  logic [WIDTH_ADDR_SIZE:0]   cmd_count,
    input  logic                       cmd_transpose,

    input  logic                       vec_valid,
    output logic                       vec_ready,
    input  lane_t [WIDTH-1:0]          vec_data,

    output MatDataWriteOp_t            write_op,
    output logic [WIDTH_ADDR_SIZE-1:0] write_param1,
    output logic [WIDTH_ADDR_SIZE-1:0] write_param2,
    output lane_t [WIDTH-1:0]          data_out,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        XPOSE = 2'd2
    } state_t;

    localparam logic [WIDTH_ADDR_SIZE:0] MAX_COUNT =
        (WIDTH_ADDR_SIZE+1)'(WIDTH);
    localparam logic [WIDTH_ADDR_SIZE-1:0] LAST_IDX =
        WIDTH_ADDR_SIZE'(WIDTH-1);

    state_t                     state_q, state_d;
    MatDataWriteOp_t            load_op_q, load_op_d;
    logic [WIDTH_ADDR_SIZE-1:0] idx_q, idx_d;
    logic [WIDTH_ADDR_SIZE:0]   remaining_q, remaining_d;
    logic                       xpose_q, xpose_d;

    MatDataWriteOp_t            op_q, op_d;
    logic [WIDTH_ADDR_SIZE-1:0] param1_q, param1_d;
    lane_t [WIDTH-1:0]          data_q, data_d;
    logic                       done_q, done_d;

    logic [WIDTH_ADDR_SIZE:0]   count_clamped;
    MatDataWriteOp_t            mode_op;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            load_op_q   <= MAT_DATA_WRITE_DISABLE;
            idx_q       <= '0;
            remaining_q <= '0;
            xpose_q     <= 1'b0;
            op_q        <= MAT_DATA_WRITE_DISABLE;
            param1_q    <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_op_q   <= load_op_d;
            idx_q       <= idx_d;
            remaining_q <= remaining_d;
            xpose_q     <= xpose_d;
            op_q        <= op_d;
            param1_q    <= param1_d;
            data_q      <= data_d;
            done_q      <= done_d;
        end
    end

    // Reserved mode 3 falls through to ROW.
    always_comb begin
        count_clamped = (cmd_count > MAX_COUNT) ? MAX_COUNT : cmd_count;
        case (cmd_mode)
            2'd1:    mode_op = MAT_DATA_WRITE_COL;
            2'd2:    mode_op = MAT_DATA_WRITE_DIAG;
            default: mode_op = MAT_DATA_WRITE_ROW;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        load_op_d   = load_op_q;
        idx_d       = idx_q;
        remaining_d = remaining_q;
        xpose_d     = xpose_q;
        op_d        = MAT_DATA_WRITE_DISABLE;
        param1_d    = param1_q;
        data_d      = data_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    load_op_d   = mode_op;
                    idx_d       = cmd_start;
                    remaining_d = count_clamped;
                    xpose_d     = cmd_transpose;
                    if (count_clamped != '0) begin
                        state_d = LOAD;
                    end else if (cmd_transpose) begin
                        state_d = XPOSE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            LOAD: begin
                if (vec_valid) begin
                    op_d        = load_op_q;
                    param1_d    = idx_q;
                    data_d      = vec_data;
                    idx_d       = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == 1) begin
                        if (xpose_q) begin
                            state_d = XPOSE;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end

            XPOSE: begin
                op_d    = MAT_DATA_WRITE_TRANSPOSE;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready    = (state_q == IDLE);
    assign vec_ready    = (state_q == LOAD);
    assign busy         = (state_q != IDLE);
    assign write_op     = op_q;
    assign write_param1 = param1_q;
    assign write_param2 = '0;
    assign data_out     = data_q;
    assign done         = done_q;

endmodule

// File: tb/tb_mat_load_ctrl.sv
// Self-checking bench for mat_load_ctrl: directed table, corner sequences
// and randomized commands against a transaction-level schedule model.

module tb_mat_load_ctrl;
    import mat_load_pkg::*;

    localparam int W  = 8;
    localparam int AW = 3;

    logic            clock = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_mode;
    logic [AW-1:0]   cmd_start;
    logic [AW:0]     cmd_count;
    logic            cmd_transpose;
    logic            vec_valid;
    logic            vec_ready;
    lane_t [W-1:0]   vec_data;
    MatDataWriteOp_t write_op;
    logic [AW-1:0]   write_param1;
    logic [AW-1:0]   write_param2;
    lane_t [W-1:0]   data_out;
    logic            busy;
    logic            done;

    mat_load_ctrl #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_mode     (cmd_mode),
        .cmd_start    (cmd_start),
        .cmd_count    (cmd_count),
        .cmd_transpose(cmd_transpose),
        .vec_valid    (vec_valid),
        .vec_ready    (vec_ready),
        .vec_data     (vec_data),
        .write_op     (write_op),
        .write_param1 (write_param1),
        .write_param2 (write_param2),
        .data_out     (data_out),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of what the write port should currently be holding.
    lane_t [W-1:0] exp_data;
    logic [AW-1:0] exp_p1;

    typedef struct {
        logic [1:0]  mode;
        int          start;
        int          count;
        bit          xp;
        logic [31:0] pat;
        int          exp_writes;
        int          exp_done;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_data(input string name, input lane_t [W-1:0] got,
                            input lane_t [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic lane_t [W-1:0] rand_vec();
        lane_t [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = $urandom;
        return v;
    endfunction

    function automatic MatDataWriteOp_t op_of(input logic [1:0] m);
        if (m == 2'd1) return MAT_DATA_WRITE_COL;
        if (m == 2'd2) return MAT_DATA_WRITE_DIAG;
        return MAT_DATA_WRITE_ROW;
    endfunction

    task automatic check_port(input string tag, input MatDataWriteOp_t eop,
                              input bit edone);
        chk({tag, "_op"}, write_op, eop);
        chk({tag, "_p1"}, write_param1, exp_p1);
        chk({tag, "_p2"}, write_param2, 0);
        chk_data({tag, "_data"}, data_out, exp_data);
        chk({tag, "_done"}, done, edone);
    endtask

    // Runs one command from an IDLE cycle. Handshake cycles are planned up
    // front from the valid pattern; each write shows one cycle later.
    task automatic run_cmd(input logic [1:0] mode, input int start,
                           input int count, input bit xp, input bit use_pat,
                           input logic [31:0] pat, output int writes,
                           output int done_cyc);
        bit  vv[1:127];
        int  n, L, E, j, k;
        bit  hs;
        MatDataWriteOp_t eop;
        writes   = 0;
        done_cyc = -1;
        n = (count > W) ? W : count;
        j = 1;
        k = 0;
        while (k < n) begin
            if (use_pat) vv[j] = (j <= 32) ? pat[j-1] : 1'b1;
            else vv[j] = (j > 40) ? 1'b1 : 1'($urandom_range(0, 1));
            if (vv[j]) k++;
            j++;
        end
        L = j - 1;
        if (n == 0) E = xp ? 2 : 1;
        else E = xp ? L + 2 : L + 1;
        for (int i = L + 1; i < E; i++) vv[i] = 1'($urandom_range(0, 1));

        cmd_valid     = 1'b1;
        cmd_mode      = mode;
        cmd_start     = AW'(start);
        cmd_count     = (AW+1)'(count);
        cmd_transpose = xp;
        vec_valid     = 1'($urandom_range(0, 1));
        vec_data      = rand_vec();
        chk("accept_ready", cmd_ready, 1);

        k = 0;
        for (j = 0; j < E; j++) begin
            if (j > 0) begin
                cmd_valid     = 1'($urandom_range(0, 1));
                cmd_mode      = 2'($urandom);
                cmd_count     = (AW+1)'($urandom);
                cmd_transpose = 1'($urandom);
                vec_valid     = vv[j];
                vec_data      = rand_vec();
                chk("vec_ready", vec_ready, (n > 0 && j <= L));
                chk("busy", busy, 1);
                chk("cmd_ready_busy", cmd_ready, 0);
            end
            hs = (n > 0 && j >= 1 && j <= L && vv[j]);
            @(posedge clock);
            #1;
            eop = MAT_DATA_WRITE_DISABLE;
            if (hs) begin
                eop      = op_of(mode);
                exp_p1   = AW'((start + k) % W);
                exp_data = vec_data;
                k++;
            end else if (j + 1 == E && xp) begin
                eop = MAT_DATA_WRITE_TRANSPOSE;
            end
            check_port("cyc", eop, (j + 1 == E));
            if (write_op inside {MAT_DATA_WRITE_ROW, MAT_DATA_WRITE_COL,
                                 MAT_DATA_WRITE_DIAG})
                writes++;
            if (done && done_cyc < 0) done_cyc = j + 1;
        end
        cmd_valid = 1'b0;
        vec_valid = 1'b0;
        chk("end_cmd_ready", cmd_ready, 1);
        chk("end_busy", busy, 0);
    endtask

    task automatic idle_cycle();
        cmd_valid = 1'b0;
        vec_valid = 1'b1;
        vec_data  = rand_vec();
        chk("idle_vec_ready", vec_ready, 0);
        @(posedge clock);
        #1;
        check_port("idle", MAT_DATA_WRITE_DISABLE, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr, dc;
        lane_t [W-1:0] va, vb;

        tbl[0] = '{2'd0, 2, 3,  1'b0, 32'hFFFFFFFF, 3, 4};
        tbl[1] = '{2'd1, 6, 4,  1'b0, 32'hFFFFFFFF, 4, 5};
        tbl[2] = '{2'd2, 0, 2,  1'b0, 32'h00000009, 2, 5};
        tbl[3] = '{2'd0, 5, 1,  1'b1, 32'hFFFFFFFF, 1, 3};
        tbl[4] = '{2'd0, 3, 0,  1'b1, 32'hFFFFFFFF, 0, 2};
        tbl[5] = '{2'd1, 1, 0,  1'b0, 32'hFFFFFFFF, 0, 1};
        tbl[6] = '{2'd0, 4, 13, 1'b0, 32'hFFFFFFFF, 8, 9};
        tbl[7] = '{2'd3, 7, 2,  1'b1, 32'h00000005, 2, 5};

        reset         = 1'b1;
        cmd_valid     = 1'b0;
        cmd_mode      = 2'd0;
        cmd_start     = '0;
        cmd_count     = '0;
        cmd_transpose = 1'b0;
        vec_valid     = 1'b0;
        vec_data      = '0;
        exp_data      = '0;
        exp_p1        = '0;
        repeat (2) @(posedge clock);
        #1;
        check_port("reset", MAT_DATA_WRITE_DISABLE, 1'b0);
        chk("reset_busy", busy, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_vec_ready", vec_ready, 0);
        reset = 1'b0;

        idle_cycle();

        for (int i = 0; i < 8; i++) begin
            run_cmd(tbl[i].mode, tbl[i].start, tbl[i].count, tbl[i].xp,
                    1'b1, tbl[i].pat, wr, dc);
            chk($sformatf("tbl%0d_writes", i), wr, tbl[i].exp_writes);
            chk($sformatf("tbl%0d_done_cyc", i), dc, tbl[i].exp_done);
        end

        // Reset after two of five vectors: no done, outputs cleared.
        cmd_valid     = 1'b1;
        cmd_mode      = 2'd0;
        cmd_start     = 3'd1;
        cmd_count     = 4'd5;
        cmd_transpose = 1'b0;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        va        = rand_vec();
        vb        = rand_vec();
        vec_valid = 1'b1;
        vec_data  = va;
        @(posedge clock);
        #1;
        vec_data = vb;
        @(posedge clock);
        #1;
        exp_p1   = 3'd2;
        exp_data = vb;
        check_port("pre_rst", MAT_DATA_WRITE_ROW, 1'b0);
        reset    = 1'b1;
        vec_data = rand_vec();
        @(posedge clock);
        #1;
        exp_p1   = '0;
        exp_data = '0;
        check_port("mid_rst", MAT_DATA_WRITE_DISABLE, 1'b0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_port("post_rst", MAT_DATA_WRITE_DISABLE, 1'b0);
        run_cmd(2'd1, 3, 5, 1'b1, 1'b0, 32'h0, wr, dc);
        chk("post_rst_writes", wr, 5);

        for (int r = 0; r < 40; r++) begin
            int c;
            c = $urandom_range(0, 15);
            run_cmd(2'($urandom), $urandom_range(0, W - 1), c,
                    1'($urandom), 1'b0, 32'h0, wr, dc);
            chk("rnd_writes", wr, (c > W) ? W : c);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
